spu_writeback_stage: RTL



---
 rtl/spu_writeback_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/spu_writeback_stage.sv
// spu_writeback_stage: latency-aligned even/odd writeback slots feeding the register file write ports (ev_*/od_* results in with ready, flush, regWr_en/addr_rt_wt/rt_wt_{even,odd} and inflight_{even,odd} out; SPU_WB_BYPASS_EN adds fwd_addr/fwd_rf_data/fwd_data)
module spu_wb_pipe #(
  parameter int QUADWORD = 128,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int STAGES = 7,
  parameter int LAT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      valid,
  output logic                      ready,
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic [QUADWORD-1:0]       data,
  input  logic [LAT_WIDTH-1:0]      lat,
  output logic                      s1_valid,
  output logic [REG_ADDR_WIDTH-1:0] s1_addr,
  output logic [QUADWORD-1:0]       s1_data,
  output logic [LAT_WIDTH:0]        inflight
);
  logic [STAGES:1] v, v_nxt;
  logic [REG_ADDR_WIDTH-1:0] a [1:STAGES];
  logic [QUADWORD-1:0] d [1:STAGES];
  logic [STAGES+1:0] v_ext;
  logic [LAT_WIDTH:0] lat_p1, cnt;
  logic acc;
  assign v_ext = {1'b0, v, 1'b0};
  assign lat_p1 = {1'b0, lat} + 1'b1;
  assign ready = lat != '0 && lat <= LAT_WIDTH'(STAGES) && !v_ext[lat_p1] && !flush;
  assign acc = valid && ready;
  assign s1_valid = v[1];
  assign s1_addr = a[1];
  assign s1_data = d[1];
  always_comb begin
    v_nxt = v >> 1;
    if (acc) v_nxt[lat] = 1'b1;
    if (flush) v_nxt[STAGES:2] = '0;
    cnt = '0;
    for (int k = 1; k <= STAGES; k++) cnt = cnt + (LAT_WIDTH+1)'(v_nxt[k]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      inflight <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        a[k] <= '0;
        d[k] <= '0;
      end
    end else begin
      v <= v_nxt;
      inflight <= cnt;
      for (int k = 1; k < STAGES; k++) begin
        a[k] <= a[k+1];
        d[k] <= d[k+1];
      end
      if (acc) begin
        a[lat] <= addr;
        d[lat] <= data;
      end
    end
  end
endmodule

module spu_writeback_stage #(
  parameter int QUADWORD = 128,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int STAGES = 7,
  parameter int LAT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic [REG_ADDR_WIDTH-1:0] ev_addr,
  input  logic [QUADWORD-1:0]       ev_data,
  input  logic [LAT_WIDTH-1:0]      ev_lat,
  input  logic                      od_valid,
  output logic                      od_ready,
  input  logic [REG_ADDR_WIDTH-1:0] od_addr,
  input  logic [QUADWORD-1:0]       od_data,
  input  logic [LAT_WIDTH-1:0]      od_lat,
  input  logic                      flush,
`ifdef SPU_WB_BYPASS_EN
  input  logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  input  logic [QUADWORD-1:0]       fwd_rf_data,
  output logic [QUADWORD-1:0]       fwd_data,
`endif
  output logic                      regWr_en_even,
  output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_even,
  output logic [QUADWORD-1:0]       rt_wt_even,
  output logic                      regWr_en_odd,
  output logic [REG_ADDR_WIDTH-1:0] addr_rt_wt_odd,
  output logic [QUADWORD-1:0]       rt_wt_odd,
  output logic [LAT_WIDTH:0]        inflight_even,
  output logic [LAT_WIDTH:0]        inflight_odd
);
  logic ev_s1, od_s1;
  spu_wb_pipe #(.QUADWORD(QUADWORD), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .STAGES(STAGES), .LAT_WIDTH(LAT_WIDTH)) u_ev (
    .clk(clk), .reset(reset), .flush(flush), .valid(ev_valid), .ready(ev_ready), .addr(ev_addr),
    .data(ev_data), .lat(ev_lat), .s1_valid(ev_s1), .s1_addr(addr_rt_wt_even), .s1_data(rt_wt_even),
    .inflight(inflight_even)
  );
  spu_wb_pipe #(.QUADWORD(QUADWORD), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .STAGES(STAGES), .LAT_WIDTH(LAT_WIDTH)) u_od (
    .clk(clk), .reset(reset), .flush(flush), .valid(od_valid), .ready(od_ready), .addr(od_addr),
    .data(od_data), .lat(od_lat), .s1_valid(od_s1), .s1_addr(addr_rt_wt_odd), .s1_data(rt_wt_odd),
    .inflight(inflight_odd)
  );
  assign regWr_en_odd = od_s1;
  assign regWr_en_even = ev_s1 && !(od_s1 && addr_rt_wt_even == addr_rt_wt_odd);
`ifdef SPU_WB_BYPASS_EN
  assign fwd_data = (od_s1 && addr_rt_wt_odd == fwd_addr) ? rt_wt_odd :
                    (ev_s1 && addr_rt_wt_even == fwd_addr) ? rt_wt_even : fwd_rf_data;
`endif
endmodule
